// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// Resolves load-use stalls, taken-branch flushes and MDU occupancy, and
// drives the PC / IF/ID / ID/EX enables.
// Optional macro HAZCTRL_PERF_EN builds saturating stall/flush counters
// plus a simulation-only event trace; without it both counters read 0.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              idex_memread,
  input  logic [4:0]        idex_rt,
  input  logic [4:0]        ifid_rs,
  input  logic [4:0]        ifid_rt,
  input  logic              ifid_uses_hilo,
  input  logic              ifid_is_mdu,
  input  logic              mdu_start,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // Loading L-1 makes the count reach zero on the L-th cycle after start.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MDU_LATENCY - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_zero;
  logic             lu;
  logic             mh;
  logic             stall;

  // $zero is never a real producer, so a load to r0 cannot create a hazard.
  assign lu       = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  assign cnt_zero = (cnt == '0);
  // HI/LO readers and new MDU ops must wait until the final MDU cycle.
  assign mh       = (state == MDU_WAIT) && !cnt_zero &&
                    (ifid_uses_hilo || ifid_is_mdu);
  // A taken branch in EX is older than anything in ID, so it wins.
  assign stall    = (lu || mh) && !branch_taken;

  // State register and MDU countdown
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: start, count down, reload on back-to-back MDU ops
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (mdu_start) begin
          state_next = MDU_WAIT;
          cnt_next   = RELOAD;
        end
      end
      MDU_WAIT: begin
        if (!cnt_zero) begin
          cnt_next = cnt - 1'b1;
        end else if (mdu_start) begin
          cnt_next = RELOAD;
        end else begin
          state_next = RUN;
        end
      end
    endcase
  end

  // Output decode: everything is forced low while reset is held
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    if (!reset) begin
      mdu_busy = (state == MDU_WAIT);
      mdu_done = (state == MDU_WAIT) && cnt_zero;
      if (branch_taken) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (stall) begin
        idex_bubble = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

`ifdef HAZCTRL_PERF_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  // Saturating hazard counters, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (branch_taken && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

`ifndef SYNTHESIS
  // Event trace for debugging pipeline behaviour in simulation
  always @(posedge clock) begin
    if (!reset) begin
      if (branch_taken) begin
        $display("FLUSH at %0t", $time);
      end else if (lu) begin
        $display("STALL LU at %0t", $time);
      end else if (mh) begin
        $display("STALL MDU at %0t", $time);
      end
    end
  end
`endif
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MDU_LATENCY=4, PERF_W=4).
// Expected control vectors are queued as stimulus is driven and popped
// when the combinational outputs are sampled mid-cycle.
module tb_hazard_ctrl;

  localparam int L  = 4;
  localparam int PW = 4;
`ifdef HAZCTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector bit order: {pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy, mdu_done}
  localparam logic [5:0] C_ZERO   = 6'b000000;
  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_FLUSH  = 6'b111100;
  localparam logic [5:0] C_MSTALL = 6'b000110;
  localparam logic [5:0] C_MBUSY  = 6'b110010;
  localparam logic [5:0] C_MDONE  = 6'b110011;

  typedef struct packed {
    logic       mr;
    logic [4:0] xrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       hilo;
    logic       ismdu;
    logic       start;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          idex_memread;
  logic [4:0]    idex_rt;
  logic [4:0]    ifid_rs;
  logic [4:0]    ifid_rt;
  logic          ifid_uses_hilo;
  logic          ifid_is_mdu;
  logic          mdu_start;
  logic          branch_taken;
  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_bubble;
  logic          mdu_busy;
  logic          mdu_done;
  logic [PW-1:0] stall_cycles;
  logic [PW-1:0] flush_count;

  int            checks = 0;
  int            errors = 0;
  logic [5:0]    exp_q[$];
  logic [PW-1:0] exp_stall = '0;
  logic [PW-1:0] exp_flush = '0;

  hazard_ctrl #(
    .MDU_LATENCY(L),
    .CNT_W      (3),
    .PERF_W     (PW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .idex_memread  (idex_memread),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_hilo(ifid_uses_hilo),
    .ifid_is_mdu   (ifid_is_mdu),
    .mdu_start     (mdu_start),
    .branch_taken  (branch_taken),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .mdu_busy      (mdu_busy),
    .mdu_done      (mdu_done),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [5:0] ctrl_now();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy, mdu_done};
  endfunction

  function automatic vec_t mk(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                              input logic [4:0] rt, input logic hilo, input logic ismdu,
                              input logic start, input logic br, input logic [5:0] e);
    vec_t v;
    v = '{mr: mr, xrt: xrt, rs: rs, rt: rt, hilo: hilo, ismdu: ismdu,
          start: start, br: br, exp: e};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    idex_memread   = v.mr;
    idex_rt        = v.xrt;
    ifid_rs        = v.rs;
    ifid_rt        = v.rt;
    ifid_uses_hilo = v.hilo;
    ifid_is_mdu    = v.ismdu;
    mdu_start      = v.start;
    branch_taken   = v.br;
  endtask

  // Update the expected perf counters for a cycle the bench expects to be a stall/flush
  task automatic account(input logic [5:0] e);
    if (PERF) begin
      if (!e[5] && (exp_stall != '1)) exp_stall = exp_stall + 1'b1;
      if (e[3] && (exp_flush != '1)) exp_flush = exp_flush + 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [5:0] o;
    @(negedge clock);
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, C_ZERO));
    #2;
    o = ctrl_now();
    checks++;
    if (o !== C_ZERO) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", o, C_ZERO);
    end
    checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_perf: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic test_load_use();
    vec_t q[$];
    vec_t v;
    logic [5:0] o, e;
    q.push_back(mk(1, 8, 8, 3, 0, 0, 0, 0, C_STALL));
    q.push_back(mk(0, 8, 8, 3, 0, 0, 0, 0, C_RUN));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    q.push_back(mk(1, 5, 3, 5, 0, 0, 0, 0, C_STALL));
    q.push_back(mk(1, 6, 3, 5, 0, 0, 0, 0, C_RUN));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(negedge clock);
      apply(v);
      exp_q.push_back(v.exp);
      account(v.exp);
      #2;
      o = ctrl_now();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL load_use[%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_mdu_timing();
    vec_t q[$];
    vec_t v;
    logic [5:0] o, e;
    q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, C_RUN));
    for (int k = 1; k < L; k++) q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, C_MSTALL));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, C_MDONE));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, C_RUN));
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(negedge clock);
      apply(v);
      exp_q.push_back(v.exp);
      account(v.exp);
      #2;
      o = ctrl_now();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL mdu_timing[T+%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t q[$];
    vec_t v;
    logic [5:0] o, e;
    q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, C_RUN));
    for (int k = 1; k < L; k++) q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, C_MSTALL));
    q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, C_MDONE));
    for (int k = 1; k < L; k++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_MBUSY));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_MDONE));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(negedge clock);
      apply(v);
      exp_q.push_back(v.exp);
      account(v.exp);
      #2;
      o = ctrl_now();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back[T+%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_priority();
    vec_t q[$];
    vec_t v;
    logic [5:0] o, e;
    logic [PW-1:0] stall_before;
    q.push_back(mk(1, 8, 8, 0, 0, 0, 0, 1, C_FLUSH));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    stall_before = exp_stall;
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(negedge clock);
      apply(v);
      exp_q.push_back(v.exp);
      account(v.exp);
      #2;
      o = ctrl_now();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL priority[%0d]: got %b expected %b", i, o, e);
      end
    end
    @(posedge clock);
    #1;
    checks++;
    if (stall_cycles !== stall_before) begin
      errors++;
      $display("[TB] FAIL priority_stall_cnt: got %0d expected %0d", stall_cycles, stall_before);
    end
    checks++;
    if (flush_count !== exp_flush) begin
      errors++;
      $display("[TB] FAIL priority_flush_cnt: got %0d expected %0d", flush_count, exp_flush);
    end
  endtask

  task automatic test_reset_mid_mdu();
    vec_t q[$];
    vec_t v;
    logic [5:0] o, e;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_RUN));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_MBUSY));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_MBUSY));
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(negedge clock);
      apply(v);
      exp_q.push_back(v.exp);
      account(v.exp);
      #2;
      o = ctrl_now();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_mdu_pre[%0d]: got %b expected %b", i, o, e);
      end
    end
    // counter is 2 here; assert reset between clock edges
    #1;
    reset = 1'b1;
    exp_stall = '0;
    exp_flush = '0;
    #1;
    o = ctrl_now();
    checks++;
    if (o !== C_ZERO || stall_cycles !== '0 || flush_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_mdu_async: got %b %0d/%0d expected %b 0/0",
               o, stall_cycles, flush_count, C_ZERO);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clock);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
      exp_q.push_back(C_RUN);
      #2;
      o = ctrl_now();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_mdu_post[%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_saturation();
    vec_t q[$];
    vec_t v;
    logic [5:0] o, e;
    logic [PW-1:0] sat_exp;
    for (int k = 0; k < 20; k++) q.push_back(mk(1, 9, 9, 0, 0, 0, 0, 0, C_STALL));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(negedge clock);
      apply(v);
      exp_q.push_back(v.exp);
      account(v.exp);
      #2;
      o = ctrl_now();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL saturation[%0d]: got %b expected %b", i, o, e);
      end
    end
    @(posedge clock);
    #1;
    sat_exp = PERF ? 4'd15 : 4'd0;
    checks++;
    if (stall_cycles !== sat_exp) begin
      errors++;
      $display("[TB] FAIL saturation_hold: got %0d expected %0d", stall_cycles, sat_exp);
    end
    checks++;
    if (stall_cycles !== exp_stall || flush_count !== exp_flush) begin
      errors++;
      $display("[TB] FAIL final_perf: got %0d/%0d expected %0d/%0d",
               stall_cycles, flush_count, exp_stall, exp_flush);
    end
  endtask

  initial begin
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, C_ZERO));
    test_reset();
    test_load_use();
    test_mdu_timing();
    test_back_to_back();
    test_priority();
    test_reset_mid_mdu();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
